// File: rtl/helppll_pkg.sv
// Shared definitions for the helper-PLL lock controller: state encoding,
// discard depth, timeout limit and accumulator guard width.
package helppll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } lock_state_t;

  localparam int DISCARD_DEPTH = 2;
  localparam int TIMEOUT_LIMIT = 1024;
  localparam int ACC_GUARD     = 8;

endpackage

// File: rtl/helppll_satacc.sv
// Saturating signed accumulator: acc <= acc - delta, clamped to the WIDTH-bit
// signed range so it never wraps; clr has priority over en.
module helppll_satacc #(
  parameter int WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] delta,
  output logic signed [WIDTH-1:0] acc
);

  logic [WIDTH:0] diff;

  // One extra bit exposes overflow as a mismatch between the top two bits.
  assign diff = {acc[WIDTH-1], acc} - {delta[WIDTH-1], delta};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      if (diff[WIDTH] != diff[WIDTH-1]) begin
        acc <= diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        acc <= diff[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/helppll_lockctl.sv
// Helper-PLL lock controller: coarse/fine frequency loop with mixed-window
// discard and lock detection. Optional timeout: define HELPPLL_LOCKCTL_TIMEOUT_EN.
module helppll_lockctl
  import helppll_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int TWIDTH     = 16,
  parameter int WIN_COARSE = 1250,
  parameter int WIN_FINE   = 125000,
  parameter int SH_COARSE  = 2,
  parameter int SH_FINE    = 6,
  parameter int TOL_COARSE = 8,
  parameter int TOL_LOCK   = 2,
  parameter int TOL_UNLOCK = 6,
  parameter int NCONS      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [DWIDTH-1:0] freqdiff,
  input  logic                     stb_freqdiff,
  output logic        [DWIDTH-1:0] refcntsamp,
  output logic signed [TWIDTH-1:0] tune,
  output logic                     tune_stb,
  output logic                     locked,
  output logic        [1:0]        state,
  output logic                     timeout
);

  localparam int AW = TWIDTH + ACC_GUARD;
  localparam int XW = (DWIDTH > AW) ? DWIDTH : AW;
  localparam int CW = $clog2(NCONS + 1);
  localparam logic [DWIDTH:0] TOLC = (DWIDTH+1)'(TOL_COARSE);
  localparam logic [DWIDTH:0] TOLL = (DWIDTH+1)'(TOL_LOCK);
  localparam logic [DWIDTH:0] TOLU = (DWIDTH+1)'(TOL_UNLOCK);
  localparam logic [CW-1:0]   NC   = CW'(NCONS);
  localparam logic signed [XW-1:0] DMAX = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [XW-1:0] DMIN = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};

  lock_state_t st, st_next;
  logic                     run;
  logic [1:0]               discard, discard_next;
  logic [CW-1:0]            consec, consec_next;
  logic [DWIDTH-1:0]        refcnt_next;
  logic signed [DWIDTH:0]   fd_x;
  logic [DWIDTH:0]          mag;
  logic signed [DWIDTH-1:0] shifted;
  logic signed [XW-1:0]     shifted_x;
  logic signed [AW-1:0]     delta_sat, s1_delta;
  logic                     used, s1_used, to_hit, s1_clr;
  logic signed [AW-1:0]     acc;

`ifdef HELPPLL_LOCKCTL_TIMEOUT_EN
  logic [15:0] to_cnt, to_cnt_next;
  logic        to_flag, to_flag_next;
`endif

  assign fd_x      = {freqdiff[DWIDTH-1], freqdiff};
  assign mag       = fd_x[DWIDTH] ? -fd_x : fd_x;
  assign shifted   = (st == ST_COARSE) ? (freqdiff >>> SH_COARSE) : (freqdiff >>> SH_FINE);
  assign shifted_x = XW'(shifted);

  // A shifted sample wider than the accumulator is pinned to its range.
  always_comb begin
    if (shifted_x > DMAX) begin
      delta_sat = DMAX[AW-1:0];
    end else if (shifted_x < DMIN) begin
      delta_sat = DMIN[AW-1:0];
    end else begin
      delta_sat = shifted_x[AW-1:0];
    end
  end

  always_comb begin
    st_next     = st;
    consec_next = consec;
    used        = 1'b0;
    to_hit      = 1'b0;
`ifdef HELPPLL_LOCKCTL_TIMEOUT_EN
    to_cnt_next  = to_cnt;
    to_flag_next = to_flag;
`endif
    if (!enable) begin
      st_next = ST_IDLE;
    end else if (st == ST_IDLE) begin
      st_next = ST_COARSE;
    end else if (stb_freqdiff && discard == 2'd0) begin
      used = 1'b1;
      case (st)
        ST_COARSE: begin
          if (mag <= TOLC) begin
            consec_next = consec + 1'b1;
            if (consec_next == NC) st_next = ST_FINE;
          end else begin
            consec_next = '0;
          end
        end
        ST_FINE: begin
          if (mag > TOLC) begin
            st_next = ST_COARSE;
          end else if (mag <= TOLL) begin
            consec_next = consec + 1'b1;
            if (consec_next == NC) st_next = ST_LOCKED;
          end else begin
            consec_next = '0;
          end
        end
        ST_LOCKED: begin
          if (mag > TOLC) begin
            st_next = ST_COARSE;
          end else if (mag > TOLU) begin
            st_next = ST_FINE;
          end
        end
        default: ;
      endcase
`ifdef HELPPLL_LOCKCTL_TIMEOUT_EN
      // Too long without locking: restart the search from a zeroed tune.
      if (st != ST_LOCKED) begin
        to_cnt_next = to_cnt + 16'd1;
        if (to_cnt_next == 16'(TIMEOUT_LIMIT)) begin
          to_hit      = 1'b1;
          st_next     = ST_COARSE;
          consec_next = '0;
          to_cnt_next = '0;
        end
      end
`endif
    end
    if (st_next != st) consec_next = '0;
`ifdef HELPPLL_LOCKCTL_TIMEOUT_EN
    if (st_next == ST_LOCKED || st_next == ST_IDLE) to_cnt_next = '0;
    to_flag_next = enable & (to_flag | to_hit);
`endif
    refcnt_next = (st_next == ST_FINE || st_next == ST_LOCKED) ? DWIDTH'(WIN_FINE)
                                                                : DWIDTH'(WIN_COARSE);
    // The two measurements straddling a window change are unusable.
    if (refcnt_next != refcntsamp) begin
      discard_next = 2'(DISCARD_DEPTH);
    end else if (stb_freqdiff && discard != 2'd0) begin
      discard_next = discard - 2'd1;
    end else begin
      discard_next = discard;
    end
  end

  // run holds everything still on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      st         <= ST_IDLE;
      discard    <= 2'(DISCARD_DEPTH);
      consec     <= '0;
      refcntsamp <= DWIDTH'(WIN_COARSE);
      locked     <= 1'b0;
      tune_stb   <= 1'b0;
      s1_used    <= 1'b0;
      s1_clr     <= 1'b0;
      s1_delta   <= '0;
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      st         <= st_next;
      discard    <= discard_next;
      consec     <= consec_next;
      refcntsamp <= refcnt_next;
      locked     <= (st_next == ST_LOCKED);
      s1_used    <= used;
      s1_clr     <= to_hit;
      s1_delta   <= delta_sat;
      tune_stb   <= s1_used;
    end
  end

`ifdef HELPPLL_LOCKCTL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (run) begin
      to_cnt  <= to_cnt_next;
      to_flag <= to_flag_next;
    end
  end
  assign timeout = to_flag;
`else
  assign timeout = 1'b0;
`endif

  helppll_satacc #(
    .WIDTH(AW)
  ) u_satacc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (s1_clr),
    .en   (s1_used),
    .delta(s1_delta),
    .acc  (acc)
  );

  assign tune  = acc[AW-1 -: TWIDTH];
  assign state = st;

endmodule

// File: doc/helppll_lockctl.md
HELPPLL_LOCKCTL -- requirements
Module: helppll_lockctl

Interface
- REQ-001 Parameters SHALL be:
  - DWIDTH, default 32, width of frequency-difference and window words.
  - TWIDTH, default 16, tuning-word width.
  - WIN_COARSE, default 1250, reference cycles per coarse window.
  - WIN_FINE, default 125000, reference cycles per fine window.
  - SH_COARSE, default 2, coarse gain right-shift.
  - SH_FINE, default 6, fine gain right-shift.
  - TOL_COARSE, default 8, coarse-to-fine threshold (counts).
  - TOL_LOCK, default 2, lock threshold.
  - TOL_UNLOCK, default 6, unlock threshold.
  - NCONS, default 4, consecutive in-tolerance samples required.
- REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, the single clock (measurement reference domain).
  - rst_n, in, 1, asynchronous active-low reset.
  - enable, in, 1, level; high runs the loop.
  - freqdiff, in, DWIDTH signed, measured help minus ref count difference.
  - stb_freqdiff, in, 1, one-cycle strobe, freqdiff valid.
  - refcntsamp, out, DWIDTH, window length driven to the measurement block.
  - tune, out, TWIDTH signed, tuning word to the helper oscillator DAC.
  - tune_stb, out, 1, one-cycle pulse on tune update.
  - locked, out, 1, lock indicator.
  - state, out, 2, state code.
  - timeout, out, 1, sticky timeout flag.

Function
- REQ-003 The FSM SHALL have four states: IDLE=0, COARSE=1, FINE=2, LOCKED=3.
- REQ-004 Transitions SHALL be:
  - IDLE->COARSE when enable=1.
  - COARSE->FINE after NCONS consecutive used samples with |freqdiff|<=TOL_COARSE.
  - FINE->LOCKED after NCONS consecutive used samples with |freqdiff|<=TOL_LOCK.
  - LOCKED->FINE on any used sample with |freqdiff|>TOL_UNLOCK.
  - FINE or LOCKED->COARSE on any used sample with |freqdiff|>TOL_COARSE.
  - Any state->IDLE within 1 cycle of enable=0.
- REQ-005 refcntsamp SHALL be WIN_COARSE in IDLE and COARSE, and WIN_FINE in FINE and LOCKED; it SHALL change only on the cycle of a state transition.
- REQ-006 After every refcntsamp change, the next 2 strobes SHALL be discarded: no tune update and no consecutive-count effect. Those strobes measure a mixed window.
- REQ-007 A used sample SHALL subtract (freqdiff>>>SH) from a TWIDTH+8-bit signed accumulator. SH is SH_COARSE in COARSE and SH_FINE otherwise. Positive freqdiff means help is fast, so tune decreases.
- REQ-008 The accumulator SHALL saturate at the signed TWIDTH+8 limits and never wrap. tune SHALL be the accumulator's top TWIDTH bits.
- REQ-009 tune and tune_stb SHALL update exactly 2 cycles after the used stb_freqdiff; tune_stb SHALL be high for exactly 1 cycle.
- REQ-010 A strobe with no discard pending in IDLE SHALL be ignored; tune SHALL hold its last value in IDLE.
- REQ-011 The consecutive counter SHALL clear on any out-of-tolerance used sample and on every state change.
- REQ-012 locked SHALL equal (state==LOCKED), registered.
- REQ-013 If stb_freqdiff coincides with enable falling, the IDLE transition SHALL win and the sample SHALL be discarded.
- REQ-014 Re-entering COARSE from IDLE SHALL keep the accumulator value (warm restart).

Reset
- REQ-015 On rst_n=0, outputs and state SHALL go asynchronously to:
  - state=IDLE
  - accumulator=0, so tune=0
  - tune_stb=0, locked=0, timeout=0
  - refcntsamp=WIN_COARSE
  - discard counter=2
  - consecutive counter=0
- REQ-016 Reset deassertion SHALL take effect on the first clk edge after rst_n rises; no state SHALL advance on that edge.

Configuration
- REQ-017 With HELPPLL_LOCKCTL_TIMEOUT_EN defined, a 16-bit used-sample counter SHALL run in COARSE and FINE and clear on entry to LOCKED or IDLE.
- REQ-018 When that counter reaches 1024, the block SHALL:
  - set timeout (sticky until reset or enable=0);
  - clear the accumulator to 0;
  - force COARSE.
- REQ-019 Without HELPPLL_LOCKCTL_TIMEOUT_EN, timeout SHALL be tied to 0 and no counter SHALL be synthesized.

Structure
- REQ-020 Package helppll_pkg SHALL hold:
  - the state encoding;
  - the discard depth constant (2);
  - the timeout limit (1024);
  - the accumulator guard width (8).
- REQ-021 The saturating accumulator SHALL be sub-module helppll_satacc: ports clk, rst_n, clr, en, delta, acc; parameter WIDTH.

Verification
- REQ-022 The bench SHALL cover these directed scenarios:
  - Reset, then enable=1, then strobes 1-2 with freqdiff=+100: discarded, tune stays 0.
  - Strobe 3 with freqdiff=+100 (coarse): tune_stb 2 cycles later; accumulator -25 (100>>>2).
  - 4 used strobes with freqdiff=+3 in COARSE: FINE entered, refcntsamp=125000, next 2 strobes discarded.
  - 4 used strobes with freqdiff=+1 in FINE: locked=1; then freqdiff=+7: state FINE, locked=0; then freqdiff=-50: state COARSE.
  - Continuous freqdiff=-32768 with SH_COARSE=0: accumulator saturates at max, no wrap.
  - With TIMEOUT_EN: 1024 used strobes of freqdiff=+20 in COARSE: timeout=1, accumulator 0, state COARSE. Without TIMEOUT_EN: timeout stays 0.
